// File: rtl/perm_pkg.sv
// Shared constants and FSM state encoding for the permutation sort controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package perm_pkg;

    localparam int N     = 8;
    localparam int IDX_W = $clog2(N);
    localparam int ENT_W = IDX_W + 1;

    // CHECK is always part of the encoding so state values do not shift
    // between builds with and without the validity pass.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SCAN  = 3'd2,
        SWAP  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/perm_checker.sv
// Validity pass: walks r[0..N-1] one entry per cycle while go is high, tracking a seen mask.
// Latency: fin on the Nth cycle of go; valid is meaningful in that same cycle.
// Backpressure: none; the caller holds go for the whole pass and drops it to clear state.
// Ports: clk, init (sync active-high reset), go (run enable), r (live entries),
//        valid (no bit-3 entry and no repeated value so far), fin (last entry this cycle).
module perm_checker #(
    parameter int N     = perm_pkg::N,
    parameter int IDX_W = perm_pkg::IDX_W,
    parameter int ENT_W = perm_pkg::ENT_W
) (
    input  logic             clk,
    input  logic             init,
    input  logic             go,
    input  logic [ENT_W-1:0] r [N-1:0],
    output logic             valid,
    output logic             fin
);

    logic [IDX_W-1:0] pos_q;
    logic [N-1:0]     seen_q;
    logic             bad_q;

    logic [ENT_W-1:0] ent;
    logic             bad_now;

    assign ent     = r[pos_q];
    // An out-of-range entry (bit 3) or a value already seen breaks the permutation.
    assign bad_now = ent[ENT_W-1] | seen_q[ent[IDX_W-1:0]];

    assign fin   = go && (pos_q == IDX_W'(N-1));
    assign valid = !(bad_q | bad_now);

    always_ff @(posedge clk) begin
        if (init || !go) begin
            pos_q  <= '0;
            seen_q <= '0;
            bad_q  <= 1'b0;
        end else begin
            pos_q  <= pos_q + IDX_W'(1);
            seen_q <= seen_q | (N'(1) << ent[IDX_W-1:0]);
            bad_q  <= bad_q | bad_now;
        end
    end

endmodule

// File: rtl/perm_sort_ctrl.sv
// Swap-command initiator: issues one register-file swap at a time until r[i]==i for all i.
// Latency: start to done = 8 + 2*swaps cycles (+8 with the CHECK pass).
// Backpressure: none; r must stay untouched by other agents while busy.
// Ports: clk, init (sync active-high reset), start, r (live entries) in;
//        swap/x/y (registered swap command), busy, done, err (pulses), swap_cnt out.
// Build option: PERM_SORT_CHECK_EN adds an N-cycle validity pass before scanning.
module perm_sort_ctrl #(
    parameter int N     = perm_pkg::N,
    parameter int IDX_W = perm_pkg::IDX_W,
    parameter int ENT_W = perm_pkg::ENT_W
) (
    input  logic             clk,
    input  logic             init,
    input  logic             start,
    input  logic [ENT_W-1:0] r [N-1:0],
    output logic             swap,
    output logic [IDX_W-1:0] x,
    output logic [IDX_W-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] swap_cnt
);
    import perm_pkg::*;

    // Entry N-1 is implied correct once 0..N-2 are, so the scan stops at N-2.
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N-2);
    // A valid permutation never needs more than N-1 swaps.
    localparam logic [IDX_W-1:0] MAX_SWAPS = IDX_W'(N-1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             swap_q, swap_d;
    logic [IDX_W-1:0] x_q, x_d;
    logic [IDX_W-1:0] y_q, y_d;

    logic             chk_go;
    logic             chk_valid;
    logic             chk_fin;
    logic [IDX_W-1:0] cur;

    assign chk_go = (state_q == CHECK);
    assign cur    = r[idx_q][IDX_W-1:0];

`ifdef PERM_SORT_CHECK_EN
    localparam state_t START_ST = CHECK;

    perm_checker #(
        .N     (N),
        .IDX_W (IDX_W),
        .ENT_W (ENT_W)
    ) u_checker (
        .clk   (clk),
        .init  (init),
        .go    (chk_go),
        .r     (r),
        .valid (chk_valid),
        .fin   (chk_fin)
    );
`else
    localparam state_t START_ST = SCAN;

    // CHECK is unreachable here; tie its exit so it would fall through to SCAN.
    assign chk_valid = 1'b1;
    assign chk_fin   = 1'b1;

    // Bit 3 of each entry plays no part in this build.
    logic [N-1:0] unused_msb;
    for (genvar g = 0; g < N; g++) begin : g_unused
        assign unused_msb[g] = r[g][ENT_W-1];
    end
    logic unused_go;
    assign unused_go = chk_go;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        swap_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = START_ST;
                end
            end
            CHECK: begin
                if (chk_fin) begin
                    state_d = chk_valid ? SCAN : ERR;
                end
            end
            SCAN: begin
                if (cur == idx_q) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (cnt_q == MAX_SWAPS) begin
                    state_d = ERR;
                end else begin
                    // Send the entry to its home slot; idx is rescanned afterwards.
                    x_d     = idx_q;
                    y_d     = cur;
                    swap_d  = 1'b1;
                    state_d = SWAP;
                end
            end
            SWAP: begin
                cnt_d   = cnt_q + IDX_W'(1);
                state_d = SCAN;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            swap_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            swap_q  <= swap_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign swap     = swap_q;
    assign x        = x_q;
    assign y        = y_q;
    assign swap_cnt = cnt_q;
    assign busy     = (state_q == CHECK) || (state_q == SCAN) || (state_q == SWAP);
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);

endmodule

// File: tb/tb_perm_sort_ctrl.sv
// Self-checking bench for perm_sort_ctrl with a behavioural register file and sort model.
// Latency: n/a.
// Backpressure: n/a.
module tb_perm_sort_ctrl;

    localparam int N     = 8;
    localparam int IDX_W = 3;
    localparam int ENT_W = 4;
    localparam int BUDGET = 300;

    typedef logic [ENT_W-1:0] vec_t [N-1:0];

    logic             clk = 1'b0;
    logic             init;
    logic             start;
    vec_t             rf;
    vec_t             ld_vec;
    logic             ld;
    logic             swap;
    logic [IDX_W-1:0] x, y, swap_cnt;
    logic             busy, done, err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    perm_sort_ctrl #(.N(N), .IDX_W(IDX_W), .ENT_W(ENT_W)) dut (
        .clk      (clk),
        .init     (init),
        .start    (start),
        .r        (rf),
        .swap     (swap),
        .x        (x),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .swap_cnt (swap_cnt)
    );

    // Register file: bench loads it, the DUT's swap strobe exchanges two entries.
    always @(posedge clk) begin
        if (ld) begin
            rf <= ld_vec;
        end else if (swap) begin
            rf[x] <= rf[y];
            rf[y] <= rf[x];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_sort(input vec_t v, input bit noise, input string tag);
        int           a [N];
        bit [N-1:0]   seen;
        bit           ok;
        bit           exp_err;
        int           s, scans, pre, exp_cyc, i, t, cyc, busy_bad;
        logic [5:0]   eq[$];
        logic [5:0]   got[$];
        logic [23:0]  lo, exp_lo;

        // Reference: place each value at its home index, rescanning after each swap.
        seen = '0; ok = 1'b1; exp_err = 1'b0; s = 0; scans = 0;
        for (int k = 0; k < N; k++) begin
            a[k] = int'(v[k][2:0]);
            if (v[k][3] || seen[a[k]]) ok = 1'b0;
            seen[a[k]] = 1'b1;
        end
`ifdef PERM_SORT_CHECK_EN
        pre = 8;
        if (!ok) exp_err = 1'b1;
`else
        pre = 0;
`endif
        if (!exp_err) begin
            i = 0;
            while (i < N-1) begin
                scans++;
                if (a[i] == i) begin
                    i++;
                end else if (s == N-1) begin
                    exp_err = 1'b1;
                    break;
                end else begin
                    eq.push_back({i[2:0], a[i][2:0]});
                    t    = a[i];
                    a[i] = a[t];
                    a[t] = t;
                    s++;
                end
            end
        end
        exp_cyc = pre + scans + s + 1;

        @(negedge clk);
        ld = 1'b1; ld_vec = v;
        @(negedge clk);
        ld = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; busy_bad = 0;
        while (1) begin
            if (swap) got.push_back({x, y});
            if (done || err) break;
            if (!busy) busy_bad++;
            if (cyc >= BUDGET) break;
            start = noise && (cyc % 3 == 0);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        chk({tag, ".in_budget"}, 32'(cyc < BUDGET), 32'd1);
        chk({tag, ".done"}, 32'(done), 32'(!exp_err));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        chk({tag, ".cycle"}, cyc, exp_cyc);
        chk({tag, ".busy"}, busy_bad, 0);
        chk({tag, ".nswaps"}, got.size(), eq.size());
        for (int k = 0; k < got.size() && k < eq.size(); k++)
            chk($sformatf("%s.pair%0d", tag, k), 32'(got[k]), 32'(eq[k]));
        chk({tag, ".swap_cnt"}, 32'(swap_cnt), s);
        if (!exp_err) begin
            for (int k = 0; k < N; k++) begin
                lo[k*3 +: 3]     = rf[k][2:0];
                exp_lo[k*3 +: 3] = 3'(k);
            end
            chk({tag, ".final_rf"}, 32'(lo), 32'(exp_lo));
        end
        @(negedge clk);
        chk({tag, ".idle"}, 32'({busy, done, err, swap}), 32'd0);
        chk({tag, ".cnt_held"}, 32'(swap_cnt), s);
    endtask

    initial begin
        vec_t v;
        vec_t cur;
        int   k, j, tmp;

        init = 1'b1; start = 1'b0; ld = 1'b0;
        for (int i = 0; i < N; i++) ld_vec[i] = '0;
        repeat (2) @(negedge clk);
        chk("reset.outs", 32'({swap, x, y, busy, done, err, swap_cnt}), 32'd0);
        init = 1'b0;

        for (int i = 0; i < N; i++) v[i] = ENT_W'(i);
        run_sort(v, 1'b0, "identity");

        for (int i = 0; i < N; i++) v[i] = ENT_W'(N-1-i);
        run_sort(v, 1'b1, "reversed");

        v[0] = 4'd1; v[1] = 4'd2; v[2] = 4'd0;
        for (int i = 3; i < N; i++) v[i] = ENT_W'(i);
        run_sort(v, 1'b0, "rot3");

        v[0] = 4'd1;
        for (int i = 1; i < N; i++) v[i] = ENT_W'(i);
        run_sort(v, 1'b0, "dup_guard");

        for (int i = 0; i < N; i++) v[i] = ENT_W'(i);
        v[2] = 4'hA;
        run_sort(v, 1'b0, "bit3");

        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < N; i++) v[i] = ENT_W'(i);
            for (int i = N-1; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                tmp = int'(v[i]); v[i] = v[j]; v[j] = ENT_W'(tmp);
            end
            if (n == 4) v[$urandom_range(N-1, 0)][3] = 1'b1;
            run_sort(v, n[0], $sformatf("rand%0d", n));
        end

        // Reset landing on a SWAP cycle drops the command on the next cycle.
        for (int i = 0; i < N; i++) v[i] = ENT_W'(N-1-i);
        @(negedge clk);
        ld = 1'b1; ld_vec = v;
        @(negedge clk);
        ld = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!swap && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("init.swap_seen", 32'(swap), 32'd1);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        chk("init.outs", 32'({swap, x, y, busy, done, err, swap_cnt}), 32'd0);
        cur = rf;
        run_sort(cur, 1'b0, "post_init");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
